// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, key-code type and scan-code transmitter state encoding.
package ps2_pkg;

    localparam logic [7:0] E0           = 8'hE0;
    localparam logic [7:0] F0           = 8'hF0;
    localparam logic [7:0] MAX_NOR_CODE = 8'd131;

    typedef logic [8:0] keycode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_E0   = 3'd1,
        ST_GAP_E0    = 3'd2,
        ST_SEND_F0   = 3'd3,
        ST_GAP_F0    = 3'd4,
        ST_SEND_CODE = 3'd5,
        ST_GAP_CODE  = 3'd6
    } tx_state_t;

    function automatic logic code_valid(input logic [7:0] code);
        return (code != 8'h00) && (code <= MAX_NOR_CODE);
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter that parks at zero; o_zero marks the end of an inter-byte gap.
module gap_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/scancode_tx.sv
// Turns make/break key events into the PS/2 Set-2 byte stream ([E0] [F0] code),
// pacing bytes with an idle gap and a ready/strobe handshake to the serializer.
module scancode_tx
    import ps2_pkg::*;
#(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brake,
    input  logic       dout_ready,
    output logic [7:0] dout,
    output logic       dout_new,
    output logic       busy,
    output logic       err,
    output logic [2:0] o_dbg_state
);

    localparam int CW = $clog2(GAP_CYCLES + 1);

    // Handshake: a byte moves only in a SEND state on a cycle where dout_ready=1;
    // dout_new is then high for exactly the following cycle, and dout keeps the
    // last byte afterwards. Events are taken only while IDLE; anything else pulses err.

    tx_state_t r_state;
    tx_state_t w_next_state;
    logic      r_ext;
    logic      r_brk;
    logic [7:0] r_code;

    logic          w_accept;
    logic          w_reject;
    logic          w_fire;
    logic [7:0]    w_byte;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_zero;

    assign w_accept = (r_state == ST_IDLE) && (make ^ brake) && code_valid(keyCode[7:0]);
    assign w_reject = (make | brake) && !w_accept;

    gap_timer #(.W(CW)) u_gap (
        .clk        (clk),
        .resetN     (resetN),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_byte       = r_code;
        w_load       = 1'b0;
        w_load_val   = CW'(GAP_CYCLES - 1);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (keyCode[8])  w_next_state = ST_SEND_E0;
                    else if (brake)  w_next_state = ST_SEND_F0;
                    else             w_next_state = ST_SEND_CODE;
                end
            end
            ST_SEND_E0: begin
                if (dout_ready) begin
                    w_fire       = 1'b1;
                    w_byte       = E0;
                    w_load       = 1'b1;
                    w_next_state = ST_GAP_E0;
                end
            end
            ST_GAP_E0: begin
                if (w_zero) w_next_state = r_brk ? ST_SEND_F0 : ST_SEND_CODE;
            end
            ST_SEND_F0: begin
                if (dout_ready) begin
                    w_fire       = 1'b1;
                    w_byte       = F0;
                    w_load       = 1'b1;
                    w_next_state = ST_GAP_F0;
                end
            end
            ST_GAP_F0: begin
                if (w_zero) w_next_state = ST_SEND_CODE;
            end
            ST_SEND_CODE: begin
                if (dout_ready) begin
                    w_fire       = 1'b1;
                    w_byte       = r_code;
                    w_load       = 1'b1;
                    // Trailing gap is one longer so busy drops GAP_CYCLES+1 after the last byte.
                    w_load_val   = CW'(GAP_CYCLES);
                    w_next_state = ST_GAP_CODE;
                end
            end
            ST_GAP_CODE: begin
                if (w_zero) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= ST_IDLE;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_code   <= 8'h00;
            dout     <= 8'h00;
            dout_new <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            dout_new <= w_fire;
            err      <= w_reject;
            busy     <= (w_next_state != ST_IDLE);
            if (w_fire) dout <= w_byte;
            if (w_accept) begin
                r_ext  <= keyCode[8];
                r_brk  <= brake;
                r_code <= keyCode[7:0];
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_scancode_tx.sv
// Directed bench for scancode_tx: expected bytes queued per event, monitor checks bytes,
// timing and a loop-back decode of the stream back into key events.
module tb_scancode_tx;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [8:0] keyCode = 9'h000;
    logic       make = 1'b0;
    logic       brake = 1'b0;
    logic       dout_ready = 1'b1;
    logic [7:0] dout;
    logic       dout_new;
    logic       busy;
    logic       err;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ev_cyc   = 0;
    int err_cnt  = 0;
    int busy_cyc = 0;
    int n_bytes  = 0;

    logic [7:0] exp_q[$];
    logic [9:0] ev_q[$];
    int         byte_cyc[$];
    logic       rx_ext = 1'b0;
    logic       rx_brk = 1'b0;

    scancode_tx #(.GAP_CYCLES(16)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .keyCode     (keyCode),
        .make        (make),
        .brake       (brake),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_new    (dout_new),
        .busy        (busy),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (make || brake) ev_cyc = cyc;
        if (resetN) begin
            if (err)  err_cnt++;
            if (busy) busy_cyc++;
            if (dout_new) begin
                n_bytes++;
                byte_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", dout);
                end else begin
                    check("byte", {24'h0, dout}, {24'h0, exp_q.pop_front()});
                end
                if (dout == E0) rx_ext = 1'b1;
                else if (dout == F0) rx_brk = 1'b1;
                else begin
                    if (ev_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL loopback_extra: got %0h expected none", {rx_brk, rx_ext, dout});
                    end else begin
                        check("loopback_event", {22'h0, rx_brk, rx_ext, dout}, {22'h0, ev_q.pop_front()});
                    end
                    rx_ext = 1'b0;
                    rx_brk = 1'b0;
                end
            end
        end else begin
            rx_ext = 1'b0;
            rx_brk = 1'b0;
        end
    end

    // driver tasks
    task automatic fire(input logic m, input logic b, input logic [8:0] k);
        @(posedge clk); #1;
        make = m; brake = b; keyCode = k;
        @(posedge clk); #1;
        make = 1'b0; brake = 1'b0;
    endtask

    task automatic expect_seq(input logic brk, input logic [8:0] k);
        if (k[8]) exp_q.push_back(E0);
        if (brk)  exp_q.push_back(F0);
        exp_q.push_back(k[7:0]);
        ev_q.push_back({brk, k});
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        repeat (3) @(negedge clk);
        while (busy === 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        #1;
        check({name, "_busy_done"}, {31'h0, busy}, 32'h0);
        check({name, "_queue_empty"}, exp_q.size(), 32'h0);
    endtask

    function automatic int gap_of(input int a, input int b);
        if (byte_cyc.size() > b) return byte_cyc[b] - byte_cyc[a];
        return -1;
    endfunction

    function automatic int first_lat();
        if (byte_cyc.size() > 0) return byte_cyc[0] - ev_cyc;
        return -1;
    endfunction

    initial begin
        int n0, e0, rel, i;

        // reset values
        @(negedge clk);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_dout_new", {31'h0, dout_new}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        resetN = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single make
        busy_cyc = 0; byte_cyc.delete();
        expect_seq(1'b0, 9'h01C);
        fire(1'b1, 1'b0, 9'h01C);
        wait_done("t1", 200);
        check("t1_nbytes", byte_cyc.size(), 32'd1);
        check("t1_latency", first_lat(), 32'd2);
        check("t1_busy_len", busy_cyc, 32'd18);

        // 2: extended break
        busy_cyc = 0; byte_cyc.delete(); e0 = err_cnt;
        expect_seq(1'b1, 9'h11C);
        fire(1'b0, 1'b1, 9'h11C);
        wait_done("t2", 300);
        check("t2_nbytes", byte_cyc.size(), 32'd3);
        check("t2_latency", first_lat(), 32'd2);
        check("t2_gap01", gap_of(0, 1), 32'd17);
        check("t2_gap12", gap_of(1, 2), 32'd17);
        check("t2_busy_len", busy_cyc, 32'd52);
        check("t2_no_err", err_cnt - e0, 32'd0);

        // 3: stall on dout_ready
        byte_cyc.delete(); n0 = n_bytes;
        dout_ready = 1'b0;
        expect_seq(1'b0, 9'h074);
        fire(1'b1, 1'b0, 9'h074);
        repeat (50) @(negedge clk);
        #1;
        check("t3_stall_nbytes", n_bytes - n0, 32'd0);
        check("t3_stall_busy", {31'h0, busy}, 32'h1);
        check("t3_stall_state", {29'h0, dbg_state}, {29'h0, ST_SEND_CODE});
        @(posedge clk); #1;
        dout_ready = 1'b1;
        rel = cyc;
        wait_done("t3", 200);
        check("t3_release_lat", (byte_cyc.size() > 0) ? byte_cyc[0] - rel : -1, 32'd1);

        // 4: rejected events, then the largest valid code
        busy_cyc = 0; e0 = err_cnt; n0 = n_bytes;
        fire(1'b1, 1'b1, 9'h01C);
        fire(1'b1, 1'b0, 9'h000);
        fire(1'b1, 1'b0, 9'h0FF);
        fire(1'b0, 1'b1, 9'h084);
        repeat (5) @(negedge clk);
        #1;
        check("t4_err_count", err_cnt - e0, 32'd4);
        check("t4_no_bytes", n_bytes - n0, 32'd0);
        check("t4_busy_low", busy_cyc, 32'd0);
        expect_seq(1'b0, 9'h083);
        fire(1'b1, 1'b0, 9'h083);
        wait_done("t4_max", 200);
        check("t4_max_bytes", n_bytes - n0, 32'd1);

        // 5: event while busy is dropped
        e0 = err_cnt; n0 = n_bytes;
        expect_seq(1'b0, 9'h11D);
        fire(1'b1, 1'b0, 9'h11D);
        @(posedge clk);
        fire(1'b0, 1'b1, 9'h01C);
        wait_done("t5", 300);
        check("t5_err", err_cnt - e0, 32'd1);
        check("t5_nbytes", n_bytes - n0, 32'd2);

        // 6: reset mid-sequence aborts
        n0 = n_bytes;
        exp_q.push_back(E0);
        fire(1'b0, 1'b1, 9'h175);
        i = 0;
        while (n_bytes == n0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t6_first_byte_seen", n_bytes - n0, 32'd1);
        repeat (5) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("t6_rst_dout", {24'h0, dout}, 32'h0);
        check("t6_rst_dout_new", {31'h0, dout_new}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        check("t6_no_more_bytes", n_bytes - n0, 32'd1);
        expect_seq(1'b0, 9'h029);
        fire(1'b1, 1'b0, 9'h029);
        wait_done("t6", 200);
        check("t6_after_reset_bytes", n_bytes - n0, 32'd2);

        check("loopback_all_seen", ev_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
